fa_exhaustive_checker: RTL and testbench
========================================

// Module: fa_exhaustive_checker
// PURPOSE
//   Hardware stimulus/response engine for the 1-bit full adder: drives all 8
//   {a,b,cin} combinations into a DUT, samples sum/carry after a settle window,
//   and compares each result against the expected full-adder value.
//   Reports pass/fail, an error count and the first failing vector.
//   Sits at the DUT's input/output boundary as the synthesizable counterpart
//   of the directed adder bench; usable on-chip as a BIST for the adder cell.
// PARAMETERS
//   SETTLE_CYCLES  2  cycles a vector is held before sampling; legal 1..255
// PORTS
//   clk             in   1  single clock, rising edge
//   rst_n           in   1  asynchronous, active-low reset
//   start           in   1  begin a run; sampled only in IDLE or DONE
//   a_o             out  1  adder operand a to DUT
//   b_o             out  1  adder operand b to DUT
//   cin_o           out  1  carry-in to DUT
//   sum_i           in   1  DUT sum
//   carry_i         in   1  DUT carry-out
//   busy            out  1  high from the start edge until done rises
//   done            out  1  level; high after a run completes, until next start
//   pass            out  1  valid while done=1; 1 iff err_count==0
//   err_count       out  4  mismatching vectors this run, 0..8
//   first_fail_vec  out  3  {a,b,cin} index of first mismatch; 0 if none
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; a_o=b_o=cin_o=0; busy=done=pass=0;
//     err_count=0; first_fail_vec=0; vector index=0; settle counter=0.
//   Vector index v (3 bits) maps to {a_o,b_o,cin_o}=v, i.e. a_o=v[2], cin_o=v[0].
//   Expected response: sum=a^b^cin, carry=(a&b)|(a&cin)|(b&cin).
//   FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//     IDLE/DONE + start=1: at that edge, drive v=0, clear err_count,
//       first_fail_vec, pass and done; set busy=1; load the counter;
//       go to SETTLE.
//     SETTLE: hold vector for SETTLE_CYCLES edges, then go to SAMPLE.
//     SAMPLE edge: compare sum_i/carry_i with the expected values for v.
//       On mismatch: err_count+=1; if this is the first mismatch,
//       first_fail_vec=v.
//       If v<7: drive v+1, go to SETTLE.
//       If v==7: go to DONE; busy=0, done=1, pass=(final err_count==0),
//       which includes the v=7 compare. Outputs keep vector 7.
//   Each vector is held SETTLE_CYCLES+1 cycles. done rises at the edge
//     8*(SETTLE_CYCLES+1) after the start edge (24 for the default).
//   start while busy=1 is ignored; the run is not restarted.
//   A sum-only, carry-only or dual mismatch on one vector counts as one error.
//   err_count max is 8 and cannot wrap; 4 bits covers every case.
//   rst_n low mid-run aborts immediately to reset values; no partial result
//     is retained, and a new start is required.
// TESTING
//   1 Correct adder model, SETTLE_CYCLES=2, start pulse -> done rises 24
//     cycles later; pass=1, err_count=0, first_fail_vec=0.
//   2 carry_i stuck at 0 -> err_count=4 (v=3,5,6,7), first_fail_vec=3, pass=0.
//   3 sum_i inverted -> err_count=8, first_fail_vec=0, pass=0; busy low
//     once done is high.
//   4 start re-pulsed at cycle 10 of a run -> ignored; done still at cycle 24.
//   5 rst_n low at cycle 13 -> all outputs 0 and state IDLE while rst_n is
//     low; a fresh start gives a full 24-cycle run with correct results.
//   6 From DONE (scenario 2), start again with a correct model -> counts
//     cleared at the start edge; final pass=1, err_count=0.

Source files
------------

// File: rtl/fa_exhaustive_checker.sv
// Exhaustive BIST engine for a 1-bit full adder: walks all eight {a,b,cin}
// vectors, samples the DUT after a settle window and records the mismatches.
module fa_exhaustive_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       cin_o,
  input  logic       sum_i,
  input  logic       carry_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0] CntLoad = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ff_q, ff_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic exp_sum, exp_carry, mismatch;

  always_comb begin
    exp_sum   = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch  = (sum_i != exp_sum) || (carry_i != exp_carry);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StSettle;
          vec_d   = 3'd0;
          cnt_d   = CntLoad;
          err_d   = 4'd0;
          ff_d    = 3'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) begin
            ff_d = vec_q;
          end
        end
        if (vec_q != 3'd7) begin
          state_d = StSettle;
          vec_d   = vec_q + 3'd1;
          cnt_d   = CntLoad;
        end else begin
          // Final verdict includes the compare made on this same edge.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 4'd0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      ff_q    <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_o            = vec_q[2];
  assign b_o            = vec_q[1];
  assign cin_o          = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ff_q;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench for fa_exhaustive_checker: a fault-injectable adder model in front of
// the checker, directed scenarios plus randomized fault masks.
module tb_fa_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a_o, b_o, cin_o;
  logic       sum_i, carry_i;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;

  // Per-vector fault masks: bit v flips sum (fs) or carry (fc) for vector v.
  logic [7:0] fs = 8'h00;
  logic [7:0] fc = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fa_exhaustive_checker #(.SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .a_o            (a_o),
    .b_o            (b_o),
    .cin_o          (cin_o),
    .sum_i          (sum_i),
    .carry_i        (carry_i),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec)
  );

  always_comb begin
    int unsigned tot;
    logic [2:0]  v;
    v       = {a_o, b_o, cin_o};
    tot     = 32'(a_o) + 32'(b_o) + 32'(cin_o);
    sum_i   = (tot % 2 == 1) ^ fs[v];
    carry_i = (tot >= 2) ^ fc[v];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count vectors whose faulty response differs from true arithmetic.
  task automatic ref_model(output int errs, output int first);
    errs  = 0;
    first = 0;
    for (int v = 0; v < 8; v++) begin
      int tot, s, c;
      tot = (v >> 2 & 1) + (v >> 1 & 1) + (v & 1);
      s   = (tot % 2) ^ int'(fs[v]);
      c   = (tot / 2) ^ int'(fc[v]);
      if (s != tot % 2 || c != tot / 2) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
  endtask

  task automatic run(input int restart_at, output int cyc);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_at_start", 32'(busy), 1);
    check("done_at_start", 32'(done), 0);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
      start = (restart_at != 0 && cyc == restart_at);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cyc, input int errs, input int first);
    check({tag, "_cycles"}, 32'(cyc), 24);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err_count), 32'(errs));
    check({tag, "_first"}, 32'(first_fail_vec), 32'(first));
    check({tag, "_pass"}, 32'(pass), 32'(errs == 0));
    check({tag, "_vec7"}, 32'({a_o, b_o, cin_o}), 7);
  endtask

  initial begin
    int cyc, errs, first;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_vec", 32'({a_o, b_o, cin_o}), 0);
    check("rst_err", 32'(err_count), 0);
    @(negedge clk) rst_n = 1'b1;

    // Correct adder
    run(0, cyc);
    check_result("good", cyc, 0, 0);

    // Carry stuck at 0: only vectors with a true carry fail
    fc = 8'b1110_1000;
    run(0, cyc);
    check_result("carry0", cyc, 4, 3);

    // Restart from DONE with a correct adder clears counts
    fc = 8'h00;
    run(0, cyc);
    check_result("rerun", cyc, 0, 0);

    // Sum inverted everywhere
    fs = 8'hFF;
    run(0, cyc);
    check_result("suminv", cyc, 8, 0);
    fs = 8'h00;

    // Start re-pulsed mid-run is ignored
    run(10, cyc);
    check_result("restart", cyc, 0, 0);

    // Reset mid-run
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_outs", 32'({a_o, b_o, cin_o, done, pass, err_count, first_fail_vec}), 0);
    repeat (3) @(posedge clk);
    #1 check("abort_hold", 32'({busy, done, a_o, b_o, cin_o}), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("idle_after_rst", 32'({busy, done}), 0);
    run(0, cyc);
    check_result("post_rst", cyc, 0, 0);

    // Randomized fault masks against the reference model
    for (int i = 0; i < 24; i++) begin
      fs = 8'($urandom);
      fc = 8'($urandom);
      if (i % 4 == 0) fs = 8'h00;
      if (i % 3 == 0) fc = 8'h00;
      if (i % 6 == 0) begin fs = 8'h00; fc = 8'h00; end
      ref_model(errs, first);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run(0, cyc);
      check_result("rand", cyc, errs, first);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
